width_12to8: RTL and testbench



---
 rtl/width_conv_pkg.sv | 10 +
 rtl/width_12to8.sv | 76 +++++++
 tb/tb_width_12to8.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/width_conv_pkg.sv
// Shared sizes and types for the 12-bit <-> 8-bit width converters.
package width_conv_pkg;
    localparam int NIB_W    = 4;
    localparam int IN_NIBS  = 3;
    localparam int OUT_NIBS = 2;
    localparam int BUF_NIBS = 5;
    localparam int BUF_W    = NIB_W * BUF_NIBS;

    typedef logic [2:0] level_t;
endpackage

// File: rtl/width_12to8.sv
// Splits 12-bit words into 8-bit bytes, MSB nibble first, through a 5-nibble FIFO buffer.
module width_12to8
    import width_conv_pkg::*;
#(
    parameter logic [NIB_W-1:0] PAD = 4'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [11:0] data_in,
    output logic        ready_in,
    input  logic        flush,
    output logic        valid_out,
    output logic [7:0]  data_out,
    output level_t      level
);
    // Handshake: a word transfers on a posedge where valid_in && ready_in; valid_in
    // without ready_in is ignored and upstream must hold the word. valid_out cannot stall.

    localparam level_t LVL_PAIR = 3'd2;
    localparam level_t LVL_ONE  = 3'd1;
    localparam level_t LVL_IN   = 3'd3;
    localparam level_t LVL_ROOM = 3'd2;

    logic [BUF_W-1:0] buf_q, buf_d, shifted;
    level_t           level_q, level_d, kept;
    logic             emit_pair, emit_pad, accept;

    always_comb begin
        emit_pair = (level_q >= LVL_PAIR);
        emit_pad  = !emit_pair && flush && (level_q == LVL_ONE);
        if (emit_pair)
            kept = level_q - LVL_PAIR;
        else if (emit_pad)
            kept = '0;
        else
            kept = level_q;

        // Oldest nibble lives at the top of buf_q; nibbles past the level are always zero.
        if (emit_pair)
            shifted = buf_q << (NIB_W * OUT_NIBS);
        else if (emit_pad)
            shifted = buf_q << NIB_W;
        else
            shifted = buf_q;

        ready_in = !rst && !flush && (kept <= LVL_ROOM);
        accept   = valid_in && ready_in;

        buf_d   = shifted;
        level_d = kept;
        if (accept) begin
            buf_d   = shifted | ({data_in, 8'h00} >> (NIB_W * int'(kept)));
            level_d = kept + LVL_IN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q     <= '0;
            level_q   <= '0;
            valid_out <= 1'b0;
            data_out  <= 8'h00;
        end else begin
            buf_q     <= buf_d;
            level_q   <= level_d;
            valid_out <= emit_pair || emit_pad;
            if (emit_pair)
                data_out <= buf_q[BUF_W-1 -: 8];
            else if (emit_pad)
                data_out <= {buf_q[BUF_W-1 -: NIB_W], PAD};
        end
    end

    assign level = level_q;
endmodule

// File: tb/tb_width_12to8.sv
// Bench for width_12to8: directed vector table, a held-valid backpressure sequence, and random traffic vs a nibble-queue model.
module tb_width_12to8;
    localparam logic [3:0] PAD = 4'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [11:0] data_in = '0;
    logic        flush = 1'b0;
    logic        ready_in;
    logic        valid_out;
    logic [7:0]  data_out;
    logic [2:0]  level;

    width_12to8 #(.PAD(PAD)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
        .ready_in(ready_in), .flush(flush), .valid_out(valid_out),
        .data_out(data_out), .level(level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: a plain queue of nibbles in stream order.
    logic [3:0] nq[$];
    logic       m_vo = 1'b0;
    logic [7:0] m_do = 8'h00;

    // Scoreboard of expected output bytes for the backpressure sequence.
    logic [7:0] exp_q[$];
    logic       sb_on = 1'b0;

    typedef struct {
        logic        r;
        logic        v;
        logic [11:0] d;
        logic        f;
        logic        e_rdy;
        logic        e_vo;
        logic [7:0]  e_do;
        logic [2:0]  e_lvl;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_ready(input logic r, input logic f);
        int n = nq.size();
        int rem = (n >= 2) ? n - 2 : n;
        return !r && !f && (rem <= 2);
    endfunction

    task automatic model_edge(input logic r, input logic v, input logic [11:0] d, input logic f);
        logic acc;
        logic [3:0] a, b;
        int n;
        acc = v && model_ready(r, f);
        n = nq.size();
        if (r) begin
            nq.delete();
            m_vo = 1'b0;
            m_do = 8'h00;
            return;
        end
        if (n >= 2) begin
            a = nq.pop_front();
            b = nq.pop_front();
            m_do = {a, b};
            m_vo = 1'b1;
        end else if (f && n == 1) begin
            a = nq.pop_front();
            m_do = {a, PAD};
            m_vo = 1'b1;
        end else begin
            m_vo = 1'b0;
        end
        if (acc) begin
            nq.push_back(d[11:8]);
            nq.push_back(d[7:4]);
            nq.push_back(d[3:0]);
        end
    endtask

    // Drive one cycle, check ready_in before the edge and registered outputs after it.
    task automatic cycle(input logic r, input logic v, input logic [11:0] d, input logic f,
                         output logic rdy);
        @(negedge clk);
        rst = r; valid_in = v; data_in = d; flush = f;
        #1;
        rdy = ready_in;
        chk("ready_in", ready_in, model_ready(r, f));
        @(posedge clk);
        model_edge(r, v, d, f);
        #1;
        chk("valid_out", valid_out, m_vo);
        chk("data_out", data_out, m_do);
        chk("level", level, nq.size());
        if (level > 3'd5) chk("level_max", level, 5);
        if (sb_on && valid_out) begin
            if (exp_q.size() == 0) chk("sb_extra_byte", data_out, 32'hdead);
            else chk("sb_byte", data_out, exp_q.pop_front());
        end
    endtask

    task automatic apply_vec(input vec_t t, input int idx);
        @(negedge clk);
        rst = t.r; valid_in = t.v; data_in = t.d; flush = t.f;
        #1;
        chk($sformatf("vec%0d_ready", idx), ready_in, t.e_rdy);
        @(posedge clk);
        model_edge(t.r, t.v, t.d, t.f);
        #1;
        chk($sformatf("vec%0d_valid", idx), valid_out, t.e_vo);
        chk($sformatf("vec%0d_data", idx), data_out, t.e_do);
        chk($sformatf("vec%0d_level", idx), level, t.e_lvl);
    endtask

    vec_t vecs[24];

    initial begin
        logic rdy;
        logic [11:0] words[6];
        logic [7:0]  bytes_exp[9];
        logic        rdy_pat[8];
        int wi, cyc;

        // Basic split
        vecs[0]  = '{1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0};
        vecs[1]  = '{1'b0, 1'b1, 12'hABC, 1'b0, 1'b1, 1'b0, 8'h00, 3'd3};
        vecs[2]  = '{1'b0, 1'b1, 12'hDEF, 1'b0, 1'b1, 1'b1, 8'hAB, 3'd4};
        vecs[3]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 8'hCD, 3'd2};
        vecs[4]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 8'hEF, 3'd0};
        vecs[5]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 8'hEF, 3'd0};
        // Odd flush
        vecs[6]  = '{1'b0, 1'b1, 12'h5A3, 1'b0, 1'b1, 1'b0, 8'hEF, 3'd3};
        vecs[7]  = '{1'b0, 1'b1, 12'h777, 1'b1, 1'b0, 1'b1, 8'h5A, 3'd1};
        vecs[8]  = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 8'h30, 3'd0};
        vecs[9]  = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 8'h30, 3'd0};
        vecs[10] = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 8'h30, 3'd0};
        // Even flush
        vecs[11] = '{1'b0, 1'b1, 12'h111, 1'b0, 1'b1, 1'b0, 8'h30, 3'd3};
        vecs[12] = '{1'b0, 1'b1, 12'h222, 1'b0, 1'b1, 1'b1, 8'h11, 3'd4};
        vecs[13] = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 8'h12, 3'd2};
        vecs[14] = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 8'h22, 3'd0};
        vecs[15] = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 8'h22, 3'd0};
        vecs[16] = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 8'h22, 3'd0};
        // Reset mid-stream at level 4
        vecs[17] = '{1'b0, 1'b1, 12'h123, 1'b0, 1'b1, 1'b0, 8'h22, 3'd3};
        vecs[18] = '{1'b0, 1'b1, 12'h456, 1'b0, 1'b1, 1'b1, 8'h12, 3'd4};
        vecs[19] = '{1'b1, 1'b1, 12'h789, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0};
        vecs[20] = '{1'b0, 1'b1, 12'h9C7, 1'b0, 1'b1, 1'b0, 8'h00, 3'd3};
        vecs[21] = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 8'h9C, 3'd1};
        vecs[22] = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 8'h70, 3'd0};
        vecs[23] = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 8'h70, 3'd0};

        for (int i = 0; i < 24; i++) apply_vec(vecs[i], i);

        // Backpressure with valid held high; 12'hFFF is presented whenever ready_in is low.
        words     = '{12'h123, 12'h456, 12'h789, 12'hABC, 12'hDEF, 12'h123};
        bytes_exp = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF1, 8'h23};
        rdy_pat   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        foreach (bytes_exp[i]) exp_q.push_back(bytes_exp[i]);
        sb_on = 1'b1;
        wi = 0;
        cyc = 0;
        while (wi < 6 && cyc < 40) begin
            if (model_ready(1'b0, 1'b0)) begin
                cycle(1'b0, 1'b1, words[wi], 1'b0, rdy);
                wi++;
            end else begin
                cycle(1'b0, 1'b1, 12'hFFF, 1'b0, rdy);
            end
            if (cyc < 8) chk($sformatf("bp_ready_pattern%0d", cyc), rdy, rdy_pat[cyc]);
            cyc++;
        end
        if (wi < 6) chk("bp_words_accepted", wi, 6);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            cycle(1'b0, 1'b0, 12'h000, 1'b0, rdy);
            cyc++;
        end
        chk("bp_bytes_left", exp_q.size(), 0);
        chk("bp_level_end", level, 0);
        sb_on = 1'b0;

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
                  12'($urandom), $urandom_range(0, 7) == 0, rdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
